// File: rtl/pipe_pkg.sv
// pipe_pkg: stage states, bundle widths and field offsets shared by the pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} stage_t;
  localparam int IDEX_CTRL_W  = 13;
  localparam int IDEX_DATA_W  = 132;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;
  localparam int IDEX_ALUCTL_LSB   = 0;
  localparam int IDEX_STORE_LSB    = 5;
  localparam int IDEX_ALUSRC_LSB   = 7;
  localparam int IDEX_REGDST_BIT   = 9;
  localparam int IDEX_MEMWRITE_BIT = 10;
  localparam int IDEX_MEMTOREG_BIT = 11;
  localparam int IDEX_REGWRITE_BIT = 12;
  localparam int IDEX_SIGNIMM_LSB  = 0;
  localparam int IDEX_IMM_LSB      = 32;
  localparam int IDEX_SHAMT_LSB    = 48;
  localparam int IDEX_RD_LSB       = 53;
  localparam int IDEX_RT_LSB       = 58;
  localparam int IDEX_RS_LSB       = 63;
  localparam int IDEX_RD2_LSB      = 68;
  localparam int IDEX_RD1_LSB      = 100;
  localparam int EXMEM_STORE_LSB    = 0;
  localparam int EXMEM_MEMWRITE_BIT = 2;
  localparam int EXMEM_MEMTOREG_BIT = 3;
  localparam int EXMEM_REGWRITE_BIT = 4;
  localparam int EXMEM_WREG_LSB     = 0;
  localparam int EXMEM_WDATA_LSB    = 5;
  localparam int EXMEM_ALUOUT_LSB   = 37;
  localparam int MEMWB_MEMTOREG_BIT = 0;
  localparam int MEMWB_REGWRITE_BIT = 1;
  localparam int MEMWB_WREG_LSB     = 0;
  localparam int MEMWB_ALUOUT_LSB   = 5;
  localparam int MEMWB_RDATA_LSB    = 37;
  function automatic logic [1:0] occ_of(stage_t s);
    return s == ST_SKID ? 2'd2 : s == ST_FULL ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+ctrl+data entry; clear beats load so a flushed accept is dropped
module pipe_slot #(
  parameter int CTRL_W   = 13,
  parameter int DATA_W   = 132,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge CLK)
    if (RST) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and optional two-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 13,
  parameter int DATA_W   = 132,
  parameter bit SKID     = 1'b1,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic accept, drain, main_load, main_clr;
  logic [CTRL_W-1:0] main_src_c;
  logic [DATA_W-1:0] main_src_d;
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_main (
    .CLK(CLK), .RST(RST), .clr(CLR | main_clr), .load(main_load),
    .in_ctrl(main_src_c), .in_data(main_src_d),
    .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
  );
  generate
    if (SKID) begin : g_skid
      stage_t state, state_nxt;
      logic skid_load, skid_clr, skid_v;
      logic [CTRL_W-1:0] skid_c;
      logic [DATA_W-1:0] skid_d;
      always_ff @(posedge CLK)
        if (RST || CLR) state <= ST_EMPTY;
        else state <= state_nxt;
      always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        case (state)
          ST_EMPTY: if (accept) begin
            main_load = 1'b1;
            state_nxt = ST_FULL;
          end
          ST_FULL: if (accept && drain) main_load = 1'b1;
          else if (accept) begin
            skid_load = 1'b1;
            state_nxt = ST_SKID;
          end else if (drain) begin
            main_clr  = 1'b1;
            state_nxt = ST_EMPTY;
          end
          ST_SKID: if (drain) begin
            main_load = 1'b1;
            skid_clr  = 1'b1;
            state_nxt = ST_FULL;
          end
          default: state_nxt = ST_EMPTY;
        endcase
      end
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
        .CLK(CLK), .RST(RST), .clr(CLR | skid_clr), .load(skid_load),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .valid(skid_v), .ctrl(skid_c), .data(skid_d)
      );
      // ready comes straight from a flop, so back-pressure never forms a combinational path
      assign in_ready   = ~skid_v;
      assign main_src_c = state == ST_SKID ? skid_c : in_ctrl;
      assign main_src_d = state == ST_SKID ? skid_d : in_data;
      assign occupancy  = occ_of(state);
    end else begin : g_pass
      assign in_ready   = ~out_valid | out_ready;
      assign main_load  = accept;
      assign main_clr   = drain & ~accept;
      assign main_src_c = in_ctrl;
      assign main_src_d = in_data;
      assign occupancy  = {1'b0, out_valid};
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the skid (SKID=1) and pass-through (SKID=0) stage variants
module tb_pipe_stage_reg;
  localparam int CW = 13;
  localparam int DW = 132;
  logic CLK = 1'b0;
  logic RST;
  logic clr_a, iv_a, or_a, ir_a, ov_a;
  logic [CW-1:0] ic_a, oc_a;
  logic [DW-1:0] id_a, od_a;
  logic [1:0] occ_a;
  logic clr_b, iv_b, or_b, ir_b, ov_b;
  logic [CW-1:0] ic_b, oc_b;
  logic [DW-1:0] id_b, od_b;
  logic [1:0] occ_b;
  logic [DW-1:0] pat;
  int pass_cnt = 0;
  int total = 0;
  always #5 CLK = ~CLK;
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLR_DATA(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .CLR(clr_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_ctrl(ic_a), .in_data(id_a), .out_valid(ov_a), .out_ready(or_a),
    .out_ctrl(oc_a), .out_data(od_a), .occupancy(occ_a)
  );
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLR_DATA(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .CLR(clr_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_ctrl(ic_b), .in_data(id_b), .out_valid(ov_b), .out_ready(or_b),
    .out_ctrl(oc_b), .out_data(od_b), .occupancy(occ_b)
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    pat = {4'hA, {16{8'hA5}}};
    RST = 1'b1;
    clr_a = 0; iv_a = 0; or_a = 0; ic_a = '0; id_a = '0;
    clr_b = 0; iv_b = 0; or_b = 0; ic_b = '0; id_b = '0;
    tick();
    chk("rst_ov", ov_a, 0);
    chk("rst_oc", oc_a, 0);
    chk("rst_ov_b", ov_b, 0);
    tick();
    RST = 1'b0;
    chk("rst_ir", ir_a, 1);
    chk("rst_occ", occ_a, 0);
    chk("rst_od", od_a, 0);
    iv_a = 1; ic_a = 13'h1FFF; id_a = pat; or_a = 1;
    tick();
    chk("fill_ov", ov_a, 1);
    chk("fill_oc", oc_a, 13'h1FFF);
    chk("fill_od", od_a, pat);
    chk("fill_occ", occ_a, 1);
    iv_a = 0;
    tick();
    chk("bubble_ov", ov_a, 0);
    chk("bubble_oc", oc_a, 0);
    chk("bubble_occ", occ_a, 0);
    for (int i = 1; i <= 8; i++) begin
      iv_a = 1; ic_a = CW'(i); id_a = DW'(i);
      tick();
      chk("stream_od", od_a, DW'(i));
      chk("stream_ov", ov_a, 1);
      chk("stream_ir", ir_a, 1);
    end
    iv_a = 0;
    tick();
    chk("stream_end_ov", ov_a, 0);
    chk("stream_end_oc", oc_a, 0);
    chk("hold_data", od_a, 8);
    or_a = 0; iv_a = 1; ic_a = 1; id_a = 1;
    tick();
    chk("stall1_ir", ir_a, 1);
    chk("stall1_occ", occ_a, 1);
    ic_a = 2; id_a = 2;
    tick();
    chk("stall2_ir", ir_a, 0);
    chk("stall2_occ", occ_a, 2);
    chk("stall2_od", od_a, 1);
    ic_a = 3; id_a = 3;
    tick();
    chk("stall3_occ", occ_a, 2);
    chk("stall3_od", od_a, 1);
    or_a = 1;
    tick();
    chk("drain_od2", od_a, 2);
    chk("drain_ov2", ov_a, 1);
    chk("drain_ir", ir_a, 1);
    tick();
    chk("drain_od3", od_a, 3);
    chk("drain_oc3", oc_a, 3);
    iv_a = 0;
    tick();
    chk("drain_end_ov", ov_a, 0);
    chk("drain_end_occ", occ_a, 0);
    or_a = 0; iv_a = 1; ic_a = 4; id_a = 4;
    tick();
    ic_a = 5; id_a = 5;
    tick();
    chk("pre_flush_occ", occ_a, 2);
    clr_a = 1; ic_a = 13'h0011; id_a = 6;
    tick();
    chk("flush_ov", ov_a, 0);
    chk("flush_oc", oc_a, 0);
    chk("flush_occ", occ_a, 0);
    chk("flush_ir", ir_a, 1);
    clr_a = 0; iv_a = 0; or_a = 1;
    tick();
    chk("post_flush_ov", ov_a, 0);
    or_a = 0; iv_a = 1; ic_a = 7; id_a = 7;
    tick();
    chk("flush_full_occ", occ_a, 1);
    clr_a = 1; ic_a = 8; id_a = 8;
    tick();
    chk("flush_acc_ov", ov_a, 0);
    chk("flush_acc_occ", occ_a, 0);
    clr_a = 0; iv_a = 0; or_a = 1;
    tick();
    chk("flush_acc_gone", ov_a, 0);
    or_a = 0; iv_a = 1; ic_a = 9; id_a = 9;
    tick();
    ic_a = 10; id_a = 10;
    tick();
    chk("pre_rst_occ", occ_a, 2);
    RST = 1; iv_a = 0;
    tick();
    RST = 0;
    chk("mid_rst_ov", ov_a, 0);
    chk("mid_rst_oc", oc_a, 0);
    chk("mid_rst_od", od_a, 0);
    chk("mid_rst_occ", occ_a, 0);
    chk("mid_rst_ir", ir_a, 1);
    or_a = 1;
    tick();
    chk("mid_rst_skid_gone", ov_a, 0);
    iv_b = 1; ic_b = 3; id_b = 'h11; or_b = 0;
    tick();
    chk("b_ov", ov_b, 1);
    chk("b_od", od_b, 'h11);
    chk("b_occ", occ_b, 1);
    ic_b = 5; id_b = 'h22;
    #1;
    chk("b_ir_stall", ir_b, 0);
    tick();
    chk("b_hold_od", od_b, 'h11);
    or_b = 1;
    #1;
    chk("b_ir_comb", ir_b, 1);
    tick();
    chk("b_replace_od", od_b, 'h22);
    chk("b_replace_oc", oc_b, 5);
    chk("b_replace_occ", occ_b, 1);
    iv_b = 0;
    tick();
    chk("b_drain_ov", ov_b, 0);
    chk("b_drain_oc", oc_b, 0);
    chk("b_drain_occ", occ_b, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register replacing the fixed per-stage registers (ID/EX first, then EX/MEM and MEM/WB). Carries a control bundle and a data bundle between stages using a valid/ready handshake. Supports flush and an optional two-entry skid buffer so back-pressure does not create a combinational ready path. On every bubble or flush, control bits are zeroed so no stray regWrite or memWrite can occur.

Parameters:
CTRL_W, 13, control bundle width (ID/EX: regWrite, memToReg, memWrite, regDst, aluSrc[1:0], store[1:0], aluControl[4:0]).
DATA_W, 132, data bundle width (ID/EX: rd1, rd2, rs, rt, rd, shamt, imm, signImm).
SKID, 1, 1 = two-entry registered-ready skid buffer; 0 = single entry with combinational in_ready.
CLR_DATA, 0, 1 = zero data on flush/bubble; 0 = data holds its last value (control is always zeroed).

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
CLR  in  1  flush: drop all held entries, synchronous
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  held entry valid
out_ready  in  1  downstream accepts (0 = stall)
out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  out  DATA_W  data bundle
occupancy  out  2  entries held: 0..1 when SKID=0, 0..2 when SKID=1

Behaviour:
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready. Both are evaluated on the rising edge of CLK.
- Reset (RST=1 at a clock edge):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Skid entry is invalid with zero contents.
  - in_ready=1 on the first cycle after reset.
  - RST overrides CLR and all handshakes.
- Flush (CLR=1, RST=0):
  - Next state is empty: out_valid=0, out_ctrl=0, occupancy=0.
  - An accept in the same cycle is discarded, and upstream still sees the handshake as complete.
  - Data is zeroed only if CLR_DATA=1.
  - in_ready=1 on the following cycle.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On accept: out_* <= in_*, out_valid <= 1.
  - On drain without accept: out_valid <= 0, out_ctrl <= 0.
  - Latency is 1 cycle.
- SKID=1: registered in_ready = ~skid_valid. State machine (encoded in package):
  - EMPTY:
    - accept -> FULL, with main <= in.
  - FULL:
    - accept & drain -> FULL, main <= in.
    - accept & ~drain -> SKID, skid <= in.
    - ~accept & drain -> EMPTY.
    - otherwise stay.
  - SKID (both entries held):
    - in_ready=0.
    - drain -> FULL, main <= skid, skid invalid with control zeroed.
    - no accept is possible in this state.
  - Ordering is strictly FIFO, and the main entry is always the one presented.
  - Latency is 1 cycle when not stalled.
  - Throughput is 1 entry per cycle under a continuous out_ready.
- out_valid=0 implies out_ctrl is all-zero in every mode, including the cycle immediately after reset or flush.
- Entries are never duplicated or lost except by CLR.
- occupancy equals the number of valid entries, updated on the same edge as the state.

Decomposition:
- Package pipe_pkg holds:
  - Stage state enum {ST_EMPTY, ST_FULL, ST_SKID}, 2-bit.
  - Localparams for bundle widths of ID/EX, EX/MEM and MEM/WB.
  - Bit-offset constants for fields within each bundle.
- One sub-module, pipe_slot: a single valid+ctrl+data register with load, clear and CLR_DATA handling. It is instantiated once for main and once for skid (skid only when SKID=1).

Test Plan:
- Reset and fill: RST=1 for 2 cycles, then in_valid=1 with ctrl=13'h1FFF and data=132'hA5..., out_ready=1.
  - During reset: out_valid=0 and out_ctrl=0.
  - Output appears 1 cycle after accept; occupancy goes 0 to 1.
- Stream: 8 back-to-back entries with data 1..8 and out_ready=1 throughout.
  - Outputs arrive in order 1..8 on consecutive cycles; in_ready stays 1.
- Stall with SKID=1: send entries 1, 2, 3 while out_ready=0.
  - Entries 1 and 2 are accepted; in_ready=0 after the second accept; occupancy=2; entry 3 is held upstream.
  - Raise out_ready: outputs 1, 2, 3 in order, with no gaps after the first.
- Flush mid-stall: occupancy=2, assert CLR=1 together with in_valid=1 and ctrl=13'h0011.
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flushed and the incoming entries never appear.
- Reset mid-operation: RST=1 while in SKID state and CLR=0.
  - All outputs and the skid entry are zero next cycle, including data (even with CLR_DATA=0).
- SKID=0 instance: out_ready=0 with one entry held.
  - in_ready=0 combinationally.
  - Toggle out_ready=1 with in_valid=1: drain and accept happen in the same cycle and the new entry replaces the old.
